// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that serialises writes from NUM_REQ requesters into one shared
// 8-bit register, reads the value back and returns a per-requester ack/err pulse.
module reg_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 err,
  output logic                 busy,
  output logic [ID_W-1:0]      gnt_id,
  output logic                 reg_w_en,
  output logic [7:0]           reg_d,
  input  logic [7:0]           reg_q,
  output logic [15:0]          wr_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic                 reg_w_en_q, reg_w_en_d;
  logic [7:0]           reg_d_q, reg_d_d;
  logic [7:0]           data_lat_q, data_lat_d;
  logic [15:0]          wr_count_q, wr_count_d;
  logic [ID_W-1:0]      win_s;
  logic [7:0]           data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_data_split
    assign data_arr[g] = req_data[8*g +: 8];
  end

  // Search starts just above the last winner, so that winner is examined last.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [ID_W-1:0]    p);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(p) + k) % NUM_REQ;
      if (!found && r[ID_W'(idx)]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Next-state and next-output computation for the write sequencer.
  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    err_d      = 1'b0;
    busy_d     = 1'b0;
    gnt_id_d   = gnt_id_q;
    ptr_d      = ptr_q;
    reg_w_en_d = 1'b0;
    reg_d_d    = reg_d_q;
    data_lat_d = data_lat_q;
    wr_count_d = wr_count_q;
    win_s      = rr_pick(req, ptr_q);
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_id_d   = win_s;
          data_lat_d = data_arr[win_s];
          reg_d_d    = data_arr[win_s];
          reg_w_en_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = WRITE;
        end else begin
          state_d    = IDLE;
        end
      end
      WRITE: begin
        busy_d  = 1'b1;
        state_d = SETTLE;
      end
      SETTLE: begin
        // reg_q already carries the value written at the end of WRITE.
        busy_d          = 1'b1;
        ack_d[gnt_id_q] = 1'b1;
        err_d           = (reg_q != data_lat_q);
        state_d         = CHECK;
      end
      CHECK: begin
        ptr_d      = gnt_id_q;
        wr_count_d = wr_count_q + 16'd1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ack_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      gnt_id_q   <= '0;
      ptr_q      <= ID_W'(NUM_REQ - 1);
      reg_w_en_q <= 1'b0;
      reg_d_q    <= 8'h00;
      data_lat_q <= 8'h00;
      wr_count_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      gnt_id_q   <= gnt_id_d;
      ptr_q      <= ptr_d;
      reg_w_en_q <= reg_w_en_d;
      reg_d_q    <= reg_d_d;
      data_lat_q <= data_lat_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign gnt_id   = gnt_id_q;
  assign reg_w_en = reg_w_en_q;
  assign reg_d    = reg_d_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural shared register that can be
// stuck at zero to provoke readback errors.
module tb_reg_write_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic                 err;
  logic                 busy;
  logic [ID_W-1:0]      gnt_id;
  logic                 reg_w_en;
  logic [7:0]           reg_d;
  logic [7:0]           reg_q;
  logic [15:0]          wr_count;
  logic [7:0]           reg_mem;
  logic                 stuck;
  int                   tests  = 0;
  int                   failed = 0;
  int                   exp_id;

  reg_write_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .err(err),
    .busy(busy), .gnt_id(gnt_id), .reg_w_en(reg_w_en), .reg_d(reg_d),
    .reg_q(reg_q), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Shared register model: captures reg_d on a write strobe.
  always @(posedge clk) begin
    if (rst) reg_mem <= 8'h00;
    else if (reg_w_en) reg_mem <= reg_d;
  end
  assign reg_q = stuck ? 8'h00 : reg_mem;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; stuck = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gnt", 32'(gnt_id), 32'h0);
    chk("rst_wen", 32'(reg_w_en), 32'h0);
    chk("rst_regd", 32'(reg_d), 32'h0);
    chk("rst_cnt", 32'(wr_count), 32'h0);

    // Single write from requester 0
    req = 4'b0001; req_data[7:0] = 8'h5A;
    step();
    chk("t1_wen", 32'(reg_w_en), 32'h1);
    chk("t1_regd", 32'(reg_d), 32'h5A);
    chk("t1_busy", 32'(busy), 32'h1);
    step();
    chk("t1_wen_off", 32'(reg_w_en), 32'h0);
    chk("t1_ack_early", 32'(ack), 32'h0);
    step();
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_err", 32'(err), 32'h0);
    step();
    req = 4'b0000;
    chk("t1_cnt", 32'(wr_count), 32'h1);
    chk("t1_busy_low", 32'(busy), 32'h0);
    chk("t1_ack_pulse", 32'(ack), 32'h0);

    // All four requesting: grant order 0,1,2,3,0
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111; req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int g = 0; g < 5; g++) begin
      exp_id = g % 4;
      step();
      chk("rr_gnt", 32'(gnt_id), 32'(exp_id));
      chk("rr_wen", 32'(reg_w_en), 32'h1);
      chk("rr_regd", 32'(reg_d), 32'h10 + 32'(exp_id));
      step();
      chk("rr_wen_off", 32'(reg_w_en), 32'h0);
      step();
      chk("rr_ack", 32'(ack), 32'h1 << exp_id);
      chk("rr_err", 32'(err), 32'h0);
      step();
      chk("rr_idle_ack", 32'(ack), 32'h0);
      chk("rr_idle_busy", 32'(busy), 32'h0);
      chk("rr_cnt", 32'(wr_count), 32'(g + 1));
    end
    req = 4'b0000;

    // Stuck register: readback mismatch from requester 2
    stuck = 1'b1;
    req = 4'b0100; req_data[23:16] = 8'hFF;
    step();
    chk("stk_gnt", 32'(gnt_id), 32'h2);
    chk("stk_regd", 32'(reg_d), 32'hFF);
    step(); step();
    chk("stk_ack", 32'(ack), 32'h4);
    chk("stk_err", 32'(err), 32'h1);
    step();
    req = 4'b0000; stuck = 1'b0;
    chk("stk_err_pulse", 32'(err), 32'h0);
    chk("stk_cnt", 32'(wr_count), 32'h6);

    // Data change and req drop after grant are ignored
    req = 4'b0010; req_data[15:8] = 8'hA5;
    step();
    req_data[15:8] = 8'h3C; req = 4'b0000;
    chk("lat_gnt", 32'(gnt_id), 32'h1);
    chk("lat_regd_w", 32'(reg_d), 32'hA5);
    step();
    chk("lat_regd_s", 32'(reg_d), 32'hA5);
    step();
    chk("lat_ack", 32'(ack), 32'h2);
    chk("lat_err", 32'(err), 32'h0);
    step();
    chk("lat_cnt", 32'(wr_count), 32'h7);

    // Reset during SETTLE aborts the transaction
    req = 4'b1000; req_data[31:24] = 8'h77;
    step();
    chk("ab_gnt", 32'(gnt_id), 32'h3);
    step();
    chk("ab_settle_busy", 32'(busy), 32'h1);
    rst = 1'b1; req = 4'b0000;
    step();
    rst = 1'b0;
    chk("ab_ack", 32'(ack), 32'h0);
    chk("ab_err", 32'(err), 32'h0);
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_gnt0", 32'(gnt_id), 32'h0);
    chk("ab_wen", 32'(reg_w_en), 32'h0);
    chk("ab_regd", 32'(reg_d), 32'h0);
    chk("ab_cnt", 32'(wr_count), 32'h0);
    step();
    chk("ab_ack_late", 32'(ack), 32'h0);
    chk("ab_err_late", 32'(err), 32'h0);
    req = 4'b1111;
    step();
    chk("ab_regrant", 32'(gnt_id), 32'h0);
    chk("ab_regd_new", 32'(reg_d), 32'h10);
    step(); step();
    chk("ab_ack_new", 32'(ack), 32'h1);
    step();
    req = 4'b0000;
    chk("ab_cnt_new", 32'(wr_count), 32'h1);

    // Counter wrap with a lone requester regranted
    force dut.wr_count_q = 16'hFFFF;
    step();
    release dut.wr_count_q;
    chk("wrap_pre", 32'(wr_count), 32'hFFFF);
    req = 4'b0001; req_data[7:0] = 8'h42;
    step();
    chk("wrap_gnt", 32'(gnt_id), 32'h0);
    chk("wrap_regd", 32'(reg_d), 32'h42);
    step(); step();
    chk("wrap_ack", 32'(ack), 32'h1);
    chk("wrap_err", 32'(err), 32'h0);
    step();
    req = 4'b0000;
    chk("wrap_cnt", 32'(wr_count), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter and sequencer that shares one 8-bit write-enabled register among NUM_REQ requesters. It grants one requester at a time, drives the register's write strobe and data, and waits one settle cycle. It then reads the register output back and returns a per-requester ack, flagging an error on readback mismatch. It sits between requester blocks and the shared register, which is the only agent driving that register's w_en/d.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- ID_W, $clog2(NUM_REQ): width of gnt_id
- clk  in  1  rising-edge clock, single domain
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester write request, level
- req_data  in  8*NUM_REQ  requester i data on bits [8i+7:8i]
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse
- err  out  1  one-cycle pulse coincident with ack on readback mismatch
- busy  out  1  high while a transaction is in flight (state != IDLE)
- gnt_id  out  ID_W  index of current/last granted requester
- reg_w_en  out  1  write strobe to shared register
- reg_d  out  8  write data to shared register
- reg_q  in  8  shared register output, for readback
- wr_count  out  16  completed transactions, wraps 0xFFFF→0

## Operation
- All outputs are registered. States are IDLE, WRITE, SETTLE and CHECK.
- IDLE behaviour:
  - If req != 0, pick the winner round-robin: search from ptr+1 upward, wrapping at NUM_REQ-1→0.
  - Latch req_data[winner] into data_lat and set gnt_id=winner.
  - Go to WRITE.
- WRITE: reg_w_en=1, reg_d=data_lat. Always go to SETTLE next.
- SETTLE: reg_w_en=0, reg_d holds data_lat. The register presents the new value on reg_q after this cycle. Always go to CHECK next.
- CHECK:
  - ack[gnt_id]=1.
  - err = (reg_q != data_lat).
  - ptr <= gnt_id.
  - wr_count <= wr_count+1.
  - Go to IDLE.
- Handshake:
  - A requester holds req high until it sees ack.
  - It deasserts req in the cycle after ack if it has no further write.
  - req_data is sampled only at grant; later changes are ignored.
  - A req drop after grant does not abort the transaction; ack is still issued.
- Fairness: the last winner has lowest priority in the next arbitration. A lone requester with req held high is regranted every transaction.
- Reset values:
  - state=IDLE, ack=0, err=0, busy=0, gnt_id=0.
  - reg_w_en=0, reg_d=0, data_lat=0, wr_count=0.
  - ptr=NUM_REQ-1, so requester 0 wins first.
- Reset mid-transaction aborts it. No ack or err is issued, and reg_w_en is low in the cycle after the reset edge.

## Timing
- Cycle T: IDLE with req!=0.
- T+1: WRITE, busy=1, reg_w_en=1.
- T+2: SETTLE, reg_w_en=0.
- T+3: CHECK, ack/err pulse.
- T+4: IDLE, earliest new grant. The transaction costs 4 cycles, with one IDLE cycle minimum between grants.
- busy is high in T+1..T+3 and low in T+4.
- reg_w_en is high for exactly one cycle per transaction and never in two consecutive cycles.
- Requests arriving during busy are held off until the next IDLE. No request is lost as long as req stays high.
- ack is never asserted for more than one cycle or on more than one bit.
- wr_count increments at the CHECK→IDLE edge, whether or not err is set.

## Test plan
- Reset then req=0001, data0=0x5A:
  - reg_w_en high exactly at T+1 with reg_d=0x5A.
  - ack=0001 at T+3, err=0, wr_count=1.
- req=1111 held, data_i=0x10+i:
  - Grant order is 0,1,2,3,0.
  - Acks arrive 4 cycles apart, with the matching reg_d in each WRITE cycle.
- Model reg_q stuck at 0x00 and write 0xFF from requester 2: ack=0100 and err=1 at T+3; wr_count still increments.
- Change req_data1 from 0xA5 to 0x3C one cycle after grant: reg_d=0xA5 and the readback compares against 0xA5.
- Assert rst during SETTLE: no ack or err afterwards, all outputs zero. The next grant goes to requester 0 when req=1111.
- Preload wr_count to 0xFFFF through 65535 transactions (or by force): the next completion gives wr_count=0x0000.
